// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial front end: shifter state,
// counter sizing and output-bit selection.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Bits needed for a counter that walks 0..width-1.
    function automatic int counter_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Bit that leaves the shifter next; sr holds the word right-aligned.
    function automatic logic next_bit(input logic [MAX_WIDTH-1:0] sr,
                                      input int                   width,
                                      input bit                   msb_first);
        return msb_first ? (((sr >> (width - 1)) & MAX_WIDTH'(1)) != '0) : sr[0];
    endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// One-deep holding register that parks the next word while the shifter
// is still busy with the current one.
module serializer_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b1;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    // NOTE: the data register has no reset; hold_full alone says whether
    // its contents mean anything, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (load) begin
            hold_data <= data_in;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one bit per clock
// out, with a one-word hold buffer so consecutive words stream gaplessly.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy
);

    localparam int              CNT_W    = counter_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam bit              MSB      = (MSB_FIRST != 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] load_word;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             hold_load;
    logic             hold_take;
    logic             do_load;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return next_bit(MAX_WIDTH'(w), WIDTH, MSB);
    endfunction

    assign data_ready = !hold_full && !reset;
    assign accept     = data_valid && data_ready;
    assign last_bit   = (state == SHIFT) && (cnt == LAST_CNT);
    assign hold_load  = accept && (state == SHIFT) && !last_bit;
    assign hold_take  = last_bit && hold_full;

    // On the wrap edge a held word takes priority; ready is low then, so
    // the two sources can never collide.
    assign do_load   = (state == IDLE && accept) || (last_bit && (hold_full || accept));
    assign load_word = hold_full ? hold_data : data_in;

    serializer_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .take     (hold_take),
        .data_in  (data_in),
        .hold_data(hold_data),
        .hold_full(hold_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_bit   <= IDLE_BIT;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (do_load) begin
            state     <= SHIFT;
            cnt       <= '0;
            shreg     <= advance(load_word);
            out_bit   <= lead_bit(load_word);
            out_valid <= 1'b1;
            busy      <= 1'b1;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state     <= IDLE;
                cnt       <= '0;
                out_bit   <= IDLE_BIT;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                shreg   <= advance(shreg);
                out_bit <= lead_bit(shreg);
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance
// share clock, reset and data; vectors plus hand-written corner sequences.
module tb_bit_serializer;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] word;
        logic       msb;
        logic [7:0] exp;   // serial order, first bit sent in exp[7]
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             dv_m, dv_l;
    logic             rdy_m, ob_m, ov_m, busy_m;
    logic             rdy_l, ob_l, ov_l, busy_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .data_in(din), .data_valid(dv_m),
        .data_ready(rdy_m), .out_bit(ob_m), .out_valid(ov_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .data_in(din), .data_valid(dv_l),
        .data_ready(rdy_l), .out_bit(ob_l), .out_valid(ov_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {out_bit, out_valid, busy, data_ready} of the selected instance.
    function automatic logic [3:0] obs(input logic msb);
        return msb ? {ob_m, ov_m, busy_m, rdy_m} : {ob_l, ov_l, busy_l, rdy_l};
    endfunction

    // Accept one word from idle and watch the following 12 cycles.
    task automatic run_word(input logic [7:0] w, input logic msb,
                            output logic [7:0] got, output int nvalid,
                            output int first, output int nbusy);
        logic [3:0] o;
        din  = w;
        dv_m = msb;
        dv_l = ~msb;
        step();
        dv_m = 1'b0;
        dv_l = 1'b0;
        din  = ~w;
        got = '0; nvalid = 0; first = -1; nbusy = 0;
        for (int k = 0; k < 12; k++) begin
            o = obs(msb);
            if (o[2]) begin
                got = {got[6:0], o[3]};
                nvalid++;
                if (first < 0) first = k;
            end
            if (o[1]) nbusy++;
            step();
        end
    endtask

    vec_t vecs[5];

    initial begin
        logic [7:0]  got;
        logic [15:0] got16;
        logic [19:0] rdy_hist;
        int          nvalid, first, nbusy, last, n1010;
        string       tag;

        vecs[0] = '{8'h0A, 1'b1, 8'h0A};
        vecs[1] = '{8'h01, 1'b0, 8'h80};
        vecs[2] = '{8'hC8, 1'b0, 8'h13};
        vecs[3] = '{8'h96, 1'b1, 8'h96};
        vecs[4] = '{8'h0A, 1'b0, 8'h50};

        reset = 1'b1; din = '0; dv_m = 1'b0; dv_l = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            check($sformatf("idle_m_c%0d", c), 32'(obs(1'b1)), 32'b0001);
            step();
        end
        check("idle_l", 32'(obs(1'b0)), 32'b0001);

        // Single words from idle
        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].word, vecs[i].msb, got, nvalid, first, nbusy);
            tag = $sformatf("vec%0d_w%02h_m%0d", i, vecs[i].word, vecs[i].msb);
            check({tag, "_bits"},  32'(got), 32'(vecs[i].exp));
            check({tag, "_nvalid"}, nvalid, 8);
            check({tag, "_first"},  first, 0);
            check({tag, "_nbusy"},  nbusy, 8);
            if (i == 0) begin
                n1010 = 0;
                for (int b = 0; b < 5; b++)
                    if (((got >> b) & 8'h0F) == 8'h0A) n1010++;
                check("detect_1010_once", n1010, 1);
            end
        end

        // Back-to-back 0xA5, 0x3C with data_valid held high
        got16 = '0; nvalid = 0; first = -1; last = -1; rdy_hist = '0;
        din = 8'hA5; dv_m = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            if (k == 0) din = 8'h3C;
            if (k == 1) begin dv_m = 1'b0; din = 8'h00; end
            rdy_hist[k] = rdy_m;
            if (ov_m) begin
                got16 = {got16[14:0], ob_m};
                nvalid++;
                if (first < 0) first = k;
                last = k;
            end
            if (k == 17) check("b2b_busy_after", 32'(busy_m), 32'd0);
            step();
        end
        check("b2b_bits", 32'(got16), 32'hA53C);
        check("b2b_nvalid", nvalid, 16);
        check("b2b_first", first, 0);
        check("b2b_last", last, 15);
        check("b2b_ready_c0", 32'(rdy_hist[0]), 32'd1);
        check("b2b_ready_held_c1", 32'(rdy_hist[1]), 32'd0);
        check("b2b_ready_held_c7", 32'(rdy_hist[7]), 32'd0);
        check("b2b_ready_back_c8", 32'(rdy_hist[8]), 32'd1);

        // Word offered exactly on the wrap edge, hold empty
        got16 = '0; nvalid = 0; first = -1; last = -1;
        din = 8'hF0; dv_m = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            dv_m = 1'b0;
            if (k == 7) begin din = 8'h5A; dv_m = 1'b1; end
            if (k == 7) check("wrap_ready", 32'(rdy_m), 32'd1);
            if (ov_m) begin
                got16 = {got16[14:0], ob_m};
                nvalid++;
                if (first < 0) first = k;
                last = k;
            end
            step();
        end
        dv_m = 1'b0;
        check("wrap_bits", 32'(got16), 32'hF05A);
        check("wrap_nvalid", nvalid, 16);
        check("wrap_last", last, 15);

        // Reset at bit 4 of 0xFF with a second word held
        din = 8'hFF; dv_m = 1'b1;
        step();
        din = 8'h81;
        step();
        dv_m = 1'b0; din = 8'h00;
        check("rst_hold_full_ready", 32'(rdy_m), 32'd0);
        step(); step(); step();
        check("rst_inflight_bit4", 32'({ov_m, ob_m}), 32'b11);
        reset = 1'b1;
        step();
        check("rst_outputs", 32'(obs(1'b1)), 32'b0000);
        reset = 1'b0;
        #1;
        check("rst_ready_after_release", 32'(rdy_m), 32'd1);
        nvalid = 0; nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ov_m) nvalid++;
            if (busy_m) nbusy++;
        end
        check("rst_no_leftover_valid", nvalid, 0);
        check("rst_no_leftover_busy", nbusy, 0);
        check("rst_idle_level", 32'(ob_m), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
